// File: rtl/mux_select_sequencer_pkg.sv
// Shared definitions for the mux select sequencer.
//  - state_t  : sequencer FSM states (IDLE, RUN, HOLD, FINISH)
//  - SEL_W    : width of the select word {S0,S1,S2}
//  - SEL_MAX  : highest select address (end value of an up-count)
//  - step_sel : next select address in the chosen direction, modulo 8
package mux_select_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int             SEL_W   = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel,
                                                input logic              down);
    return down ? (sel - 3'd1) : (sel + 3'd1);
  endfunction

endpackage

// File: rtl/mux_select_sequencer_tick_divider.sv
// Prescaler producing one tick every TICK_DIV enabled clocks.
//  clk  : system clock, rising edge
//  rst  : asynchronous active-high reset, count returns to 0
//  en   : count advances only while high
//  clr  : returns the count to 0 (wins over en)
//  tick : one-cycle pulse while the count sits at its terminal value and en is high;
//         the count wraps to 0 on that same edge
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == TERM) ? '0 : (cnt_q + CNT_W'(1));
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Select-word sequencer for an 8-to-1 data-select stage.
// Steps a 3-bit select address every TICK_DIV clocks, up or down,
// continuous (wrapping) or one-shot, with load, pause and stop.
//  clk, rst          : clock (rising edge), asynchronous active-high reset
//  start             : begin a run (IDLE only); latches mode_down and one_shot
//  stop              : abort to IDLE from any state, select value kept
//  mode_down         : 0 = count up, 1 = count down
//  one_shot          : 1 = end the run at the range end instead of wrapping
//  pause             : level, freezes stepping and the prescaler
//  load, load_val    : load the select word (IDLE only)
//  S0, S1, S2        : registered select word, S0 = MSB
//  busy              : high in RUN or HOLD
//  step              : one-cycle pulse coincident with each new select value
//  done              : one-cycle pulse when a one-shot run ends
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_down,
  input  logic       one_shot,
  input  logic       pause,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       busy,
  output logic       step,
  output logic       done
);

  state_t           state_q, state_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic             down_q, down_nx;
  logic             os_q, os_nx;
  logic             busy_q, busy_nx;
  logic             step_q, step_nx;
  logic             done_q, done_nx;

  logic             active;
  logic             tick_en;
  logic             tick_clr;
  logic             tick;
  logic             at_end;

  // Prescaler runs in RUN, and in HOLD on the cycle pause drops, so a pause
  // delays the next step by exactly the number of paused cycles.
  assign active   = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign tick_en  = active && !stop && !pause;
  assign tick_clr = !active;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign at_end = down_q ? (sel_q == '0) : (sel_q == SEL_MAX);

  always_comb begin
    state_nx = state_q;
    sel_nx   = sel_q;
    down_nx  = down_q;
    os_nx    = os_q;
    step_nx  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (load) begin
            sel_nx = load_val;
          end
          if (start) begin
            state_nx = ST_RUN;
            down_nx  = mode_down;
            os_nx    = one_shot;
          end
        end
      end

      ST_RUN, ST_HOLD: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (pause) begin
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_RUN;
          if (tick) begin
            if (os_q && at_end) begin
              state_nx = ST_FINISH;
            end else begin
              sel_nx  = step_sel(sel_q, down_q);
              step_nx = 1'b1;
            end
          end
        end
      end

      ST_FINISH: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    busy_nx = (state_nx == ST_RUN) || (state_nx == ST_HOLD);
    done_nx = (state_nx == ST_FINISH);
  end

  // Output stage: every output is a register, nothing combinational reaches a port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      down_q  <= 1'b0;
      os_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      sel_q   <= sel_nx;
      down_q  <= down_nx;
      os_q    <= os_nx;
      busy_q  <= busy_nx;
      step_q  <= step_nx;
      done_q  <= done_nx;
    end
  end

  assign S0   = sel_q[2];
  assign S1   = sel_q[1];
  assign S2   = sel_q[0];
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
module tb_mux_select_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode_down;
  logic       one_shot;
  logic       pause;
  logic       load;
  logic [2:0] load_val;
  logic       S0, S1, S2;
  logic       busy, step, done;
  logic [2:0] sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  assign sel_o = {S0, S1, S2};

  mux_select_sequencer #(
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode_down (mode_down),
    .one_shot  (one_shot),
    .pause     (pause),
    .load      (load),
    .load_val  (load_val),
    .S0        (S0),
    .S1        (S1),
    .S2        (S2),
    .busy      (busy),
    .step      (step),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n rising edges and land 1 time unit after the last one
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int s, input int st, input int b, input int d);
    check({tag, ".sel"},  8'(sel_o), 8'(s));
    check({tag, ".step"}, 8'(step),  8'(st));
    check({tag, ".busy"}, 8'(busy),  8'(b));
    check({tag, ".done"}, 8'(done),  8'(d));
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode_down = 0; one_shot = 0;
    pause = 0; load = 0; load_val = 3'd0;

    // reset state
    clk_n(2);
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    clk_n(1);
    check_outs("idle", 0, 0, 0, 0);

    // continuous up count with wrap, step every 4th clock
    start = 1; mode_down = 0; one_shot = 0;
    clk_n(1);
    start = 0;
    check_outs("up.k0", 0, 0, 1, 0);
    for (int k = 1; k <= 36; k++) begin
      clk_n(1);
      check_outs($sformatf("up.k%0d", k), (k / 4) % 8, (k % 4 == 0) ? 1 : 0, 1, 0);
    end
    stop = 1;
    clk_n(1);
    stop = 0;
    check_outs("up.stop", 1, 0, 0, 0);

    // load + start together, one-shot down from 101
    load_val = 3'd5; load = 1; start = 1; mode_down = 1; one_shot = 1;
    clk_n(1);
    load = 0; start = 0; mode_down = 0; one_shot = 0;
    check_outs("dn.k0", 5, 0, 1, 0);
    for (int k = 1; k <= 25; k++) begin
      clk_n(1);
      if (k <= 20)
        check_outs($sformatf("dn.k%0d", k), 5 - k / 4, (k % 4 == 0) ? 1 : 0, 1, 0);
      else if (k < 24)
        check_outs($sformatf("dn.k%0d", k), 0, 0, 1, 0);
      else if (k == 24)
        check_outs($sformatf("dn.k%0d", k), 0, 0, 0, 1);
      else
        check_outs($sformatf("dn.k%0d", k), 0, 0, 0, 0);
    end

    // pause for 10 cycles with prescaler at 2
    start = 1; mode_down = 0; one_shot = 0;
    clk_n(1);
    start = 0;
    clk_n(4);
    check_outs("pz.first", 1, 1, 1, 0);
    clk_n(2);
    pause = 1;
    for (int k = 0; k < 10; k++) begin
      clk_n(1);
      check_outs($sformatf("pz.hold%0d", k), 1, 0, 1, 0);
    end
    pause = 0;
    clk_n(1);
    check_outs("pz.rel1", 1, 0, 1, 0);
    clk_n(1);
    check_outs("pz.rel2", 2, 1, 1, 0);

    // stop during HOLD at 110
    clk_n(16);
    check_outs("st.at6", 6, 1, 1, 0);
    pause = 1;
    clk_n(1);
    check_outs("st.hold", 6, 0, 1, 0);
    stop = 1;
    clk_n(1);
    stop = 0; pause = 0;
    check_outs("st.idle", 6, 0, 0, 0);
    clk_n(1);
    check_outs("st.idle2", 6, 0, 0, 0);

    // resume from 110, one-shot up ends at 111
    start = 1; one_shot = 1;
    clk_n(1);
    start = 0; one_shot = 0;
    for (int k = 1; k <= 9; k++) begin
      clk_n(1);
      if (k < 4)       check_outs($sformatf("os.k%0d", k), 6, 0, 1, 0);
      else if (k == 4) check_outs($sformatf("os.k%0d", k), 7, 1, 1, 0);
      else if (k < 8)  check_outs($sformatf("os.k%0d", k), 7, 0, 1, 0);
      else if (k == 8) check_outs($sformatf("os.k%0d", k), 7, 0, 0, 1);
      else             check_outs($sformatf("os.k%0d", k), 7, 0, 0, 0);
    end

    // one-shot started at the end value ends on its first tick
    start = 1; one_shot = 1;
    clk_n(1);
    start = 0; one_shot = 0;
    clk_n(3);
    check_outs("oe.k3", 7, 0, 1, 0);
    clk_n(1);
    check_outs("oe.k4", 7, 0, 0, 1);
    clk_n(1);
    check_outs("oe.k5", 7, 0, 0, 0);

    // start/load while busy are ignored; reset mid-run
    start = 1; mode_down = 0; one_shot = 0;
    clk_n(1);
    start = 0;
    clk_n(1);
    start = 1; load = 1; load_val = 3'd3;
    clk_n(1);
    start = 0; load = 0;
    check_outs("ig.k2", 7, 0, 1, 0);
    clk_n(1);
    check_outs("ig.k3", 7, 0, 1, 0);
    clk_n(1);
    check_outs("ig.k4", 0, 1, 1, 0);
    #2;
    rst = 1;
    #1;
    check_outs("rst.async", 0, 0, 0, 0);
    clk_n(1);
    rst = 0;
    clk_n(2);
    check_outs("rst.after", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
